// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET from commit, updates trap CSRs, redirects fetch.
// Define TRAP_VECTORED_EN to honour mtvec VECTORED mode for interrupts; otherwise every trap targets the mtvec base.
module trap_controller #(
  parameter int               MXLEN        = 64,
  parameter logic [MXLEN-3:0] BOOT_ADDRESS = 'h100
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             exc_valid_i,
  input  logic [5:0]       exc_code_i,
  input  logic [MXLEN-1:0] exc_epc_i,
  input  logic [MXLEN-1:0] exc_tval_i,
  input  logic             mret_valid_i,
  input  logic [15:0]      irq_pending_i,
  input  logic [MXLEN-1:0] mtvec_i,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [MXLEN-1:0] csr_wdata_i,
  output logic             busy_o,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [MXLEN-1:0] redirect_pc_o,
  output logic [MXLEN-1:0] mepc_o,
  output logic [MXLEN-1:0] mcause_o,
  output logic [MXLEN-1:0] mtval_o,
  output logic             mstatus_mie_o,
  output logic             mstatus_mpie_o,
  output logic [1:0]       mstatus_mpp_o,
  output logic [1:0]       priv_o
);

  localparam logic [1:0] ST_BOOT     = 2'b00;
  localparam logic [1:0] ST_IDLE     = 2'b01;
  localparam logic [1:0] ST_REDIRECT = 2'b10;

  localparam logic [1:0] PRIV_M   = 2'b11;
  localparam logic [1:0] PRIV_U   = 2'b00;
  localparam logic [1:0] MPP_RSVD = 2'b10;

  localparam logic [MXLEN-1:0] BOOT_PC = {BOOT_ADDRESS, 2'b00};
  // Implemented interrupt codes: 1, 3, 5, 7, 9, 11, 13.
  localparam logic [15:0] IRQ_IMPL = 16'h2AAA;

  logic [1:0]       state_reg;
  logic             redirect_valid_reg;
  logic [MXLEN-1:0] redirect_pc_reg;
  logic [MXLEN-1:0] mepc_reg;
  logic [MXLEN-1:0] mcause_reg;
  logic [MXLEN-1:0] mtval_reg;
  logic             mie_reg;
  logic             mpie_reg;
  logic [1:0]       mpp_reg;
  logic [1:0]       priv_reg;

  logic             is_idle;
  logic [15:0]      irq_impl;
  logic             irq_enabled;
  logic             exc_take;
  logic             irq_take;
  logic             mret_take;
  logic             trap_take;
  logic [3:0]       irq_code;
  logic [5:0]       trap_code;
  logic [MXLEN-1:0] trap_base;
  logic [MXLEN-1:0] trap_target;
  logic [MXLEN-1:0] mcause_next;
  logic [MXLEN-1:0] mepc_next;

  assign is_idle     = (state_reg == ST_IDLE);
  assign irq_impl    = irq_pending_i & IRQ_IMPL;
  assign irq_enabled = (priv_reg != PRIV_M) || mie_reg;

  assign exc_take  = is_idle && exc_valid_i;
  assign irq_take  = is_idle && !exc_valid_i && (irq_impl != 16'h0) && irq_enabled;
  assign mret_take = is_idle && !exc_valid_i && !irq_take && mret_valid_i && (priv_reg == PRIV_M);
  assign trap_take = exc_take || irq_take;

  always_comb begin
    irq_code = 4'd0;
    if      (irq_impl[11]) irq_code = 4'd11;
    else if (irq_impl[3])  irq_code = 4'd3;
    else if (irq_impl[7])  irq_code = 4'd7;
    else if (irq_impl[9])  irq_code = 4'd9;
    else if (irq_impl[1])  irq_code = 4'd1;
    else if (irq_impl[5])  irq_code = 4'd5;
    else if (irq_impl[13]) irq_code = 4'd13;
  end

  assign trap_code = exc_take ? exc_code_i : {2'b00, irq_code};

  always_comb begin
    mcause_next              = '0;
    mcause_next[5:0]         = trap_code;
    mcause_next[MXLEN-1]     = irq_take;
  end

  // Interrupts record the next PC verbatim; exceptions clear the halfword bit.
  assign mepc_next = exc_take ? {exc_epc_i[MXLEN-1:1], 1'b0} : exc_epc_i;

  assign trap_base = {mtvec_i[MXLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_target = (irq_take && (mtvec_i[1:0] == 2'b01))
                     ? trap_base + {{(MXLEN-6){1'b0}}, irq_code, 2'b00}
                     : trap_base;
`else
  logic mode_unused;
  assign mode_unused = ^mtvec_i[1:0];
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg          <= ST_BOOT;
      redirect_valid_reg <= 1'b1;
      redirect_pc_reg    <= BOOT_PC;
      mepc_reg           <= '0;
      mcause_reg         <= '0;
      mtval_reg          <= '0;
      mie_reg            <= 1'b0;
      mpie_reg           <= 1'b0;
      mpp_reg            <= PRIV_M;
      priv_reg           <= PRIV_M;
    end else begin
      case (state_reg)
        ST_BOOT: begin
          if (redirect_ready_i) begin
            state_reg          <= ST_IDLE;
            redirect_valid_reg <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (trap_take || mret_take) begin
            state_reg          <= ST_REDIRECT;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= trap_take ? trap_target : mepc_reg;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            state_reg          <= ST_IDLE;
            redirect_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg          <= ST_BOOT;
          redirect_valid_reg <= 1'b1;
          redirect_pc_reg    <= BOOT_PC;
        end
      endcase

      // A trap or MRET update takes precedence over a coincident CSR write.
      if (trap_take) begin
        mepc_reg   <= mepc_next;
        mcause_reg <= mcause_next;
        mtval_reg  <= exc_take ? exc_tval_i : '0;
        mpie_reg   <= mie_reg;
        mie_reg    <= 1'b0;
        mpp_reg    <= priv_reg;
        priv_reg   <= PRIV_M;
      end else if (mret_take) begin
        mie_reg  <= mpie_reg;
        mpie_reg <= 1'b1;
        priv_reg <= mpp_reg;
        mpp_reg  <= PRIV_U;
      end else if (csr_we_i) begin
        case (csr_addr_i)
          12'h300: begin
            mie_reg  <= csr_wdata_i[3];
            mpie_reg <= csr_wdata_i[7];
            if (csr_wdata_i[12:11] != MPP_RSVD) mpp_reg <= csr_wdata_i[12:11];
          end
          12'h341: mepc_reg   <= {csr_wdata_i[MXLEN-1:1], 1'b0};
          12'h342: mcause_reg <= csr_wdata_i;
          12'h343: mtval_reg  <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign busy_o           = (state_reg != ST_IDLE);
  assign redirect_valid_o = redirect_valid_reg;
  assign redirect_pc_o    = redirect_pc_reg;
  assign mepc_o           = mepc_reg;
  assign mcause_o         = mcause_reg;
  assign mtval_o          = mtval_reg;
  assign mstatus_mie_o    = mie_reg;
  assign mstatus_mpie_o   = mpie_reg;
  assign mstatus_mpp_o    = mpp_reg;
  assign priv_o           = priv_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Randomized bench for trap_controller against a transaction-level model of the trap CSRs and redirects.
module tb_trap_controller;

  localparam logic [63:0] BOOT_PC = 64'h400;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif
  localparam int IRQ_ORDER [7] = '{11, 3, 7, 9, 1, 5, 13};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        exc_valid = 1'b0;
  logic [5:0]  exc_code = '0;
  logic [63:0] exc_epc = '0;
  logic [63:0] exc_tval = '0;
  logic        mret_valid = 1'b0;
  logic [15:0] irq_pending = '0;
  logic [63:0] mtvec = '0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic        busy;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [63:0] redirect_pc;
  logic [63:0] mepc, mcause, mtval;
  logic        mie, mpie;
  logic [1:0]  mpp, priv;

  trap_controller #(.MXLEN(64), .BOOT_ADDRESS(62'h100)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .exc_valid_i      (exc_valid),
    .exc_code_i       (exc_code),
    .exc_epc_i        (exc_epc),
    .exc_tval_i       (exc_tval),
    .mret_valid_i     (mret_valid),
    .irq_pending_i    (irq_pending),
    .mtvec_i          (mtvec),
    .csr_we_i         (csr_we),
    .csr_addr_i       (csr_addr),
    .csr_wdata_i      (csr_wdata),
    .busy_o           (busy),
    .redirect_valid_o (redirect_valid),
    .redirect_ready_i (redirect_ready),
    .redirect_pc_o    (redirect_pc),
    .mepc_o           (mepc),
    .mcause_o         (mcause),
    .mtval_o          (mtval),
    .mstatus_mie_o    (mie),
    .mstatus_mpie_o   (mpie),
    .mstatus_mpp_o    (mpp),
    .priv_o           (priv)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int txn_count = 0;

  // Architectural model state
  logic [63:0] m_mepc, m_mcause, m_mtval;
  logic        m_mie, m_mpie;
  logic [1:0]  m_mpp, m_priv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mepc = '0; m_mcause = '0; m_mtval = '0;
    m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b11; m_priv = 2'b11;
  endtask

  task automatic check_csrs(input string tag);
    check({tag, "_mepc"},   mepc,   m_mepc);
    check({tag, "_mcause"}, mcause, m_mcause);
    check({tag, "_mtval"},  mtval,  m_mtval);
    check({tag, "_mie"},    64'(mie),  64'(m_mie));
    check({tag, "_mpie"},   64'(mpie), 64'(m_mpie));
    check({tag, "_mpp"},    64'(mpp),  64'(m_mpp));
    check({tag, "_priv"},   64'(priv), 64'(m_priv));
  endtask

  function automatic int sel_irq(input logic [15:0] p);
    for (int i = 0; i < 7; i++)
      if (p[IRQ_ORDER[i]]) return IRQ_ORDER[i];
    return -1;
  endfunction

  task automatic model_csr_write(input logic [11:0] a, input logic [63:0] w);
    case (a)
      12'h300: begin
        m_mie = w[3];
        m_mpie = w[7];
        if (w[12:11] != 2'b10) m_mpp = w[12:11];
      end
      12'h341: m_mepc = w & ~64'h1;
      12'h342: m_mcause = w;
      12'h343: m_mtval = w;
      default: ;
    endcase
  endtask

  task automatic model_trap(input bit intr, input int code, input logic [63:0] epc,
                            input logic [63:0] tval, input logic [63:0] tvec,
                            output logic [63:0] target);
    m_mepc = intr ? epc : (epc & ~64'h1);
    m_mcause = 64'(code);
    m_mcause[63] = intr;
    m_mtval = intr ? 64'h0 : tval;
    m_mpie = m_mie;
    m_mie = 1'b0;
    m_mpp = m_priv;
    m_priv = 2'b11;
    target = tvec & ~64'h3;
    if (intr && VEC_EN && tvec[1:0] == 2'b01) target = target + 64'(4 * code);
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 12'h300;
      1: return 12'h341;
      2: return 12'h342;
      3: return 12'h343;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic clear_inputs();
    exc_valid = 1'b0; mret_valid = 1'b0; irq_pending = '0; csr_we = 1'b0;
  endtask

  task automatic boot_handshake(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("boot_valid", 64'(redirect_valid), 64'h1);
      check("boot_pc", redirect_pc, BOOT_PC);
      check("boot_busy", 64'(busy), 64'h1);
      @(negedge clk);
    end
    check("boot_valid", 64'(redirect_valid), 64'h1);
    check("boot_pc", redirect_pc, BOOT_PC);
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check("boot_done_valid", 64'(redirect_valid), 64'h0);
    check("boot_done_busy", 64'(busy), 64'h0);
    check_csrs("boot_done");
    $display("txn %0d: boot redirect 0x%0h accepted after %0d wait cycles", txn_count++, BOOT_PC, delay);
  endtask

  // Applies one cycle of commit inputs in IDLE, then follows any redirect to completion.
  task automatic run_txn(input string kind, input logic e, input logic [5:0] code,
                         input logic [63:0] epc, input logic [63:0] tval, input logic mr,
                         input logic [15:0] irq, input logic [63:0] tvec, input logic we,
                         input logic [11:0] addr, input logic [63:0] wdata, input int hold);
    int ic;
    bit taken;
    logic [63:0] target;
    check("pre_busy", 64'(busy), 64'h0);
    exc_valid = e; exc_code = code; exc_epc = epc; exc_tval = tval;
    mret_valid = mr; irq_pending = irq; mtvec = tvec;
    csr_we = we; csr_addr = addr; csr_wdata = wdata;
    ic = sel_irq(irq);
    taken = 1'b0;
    target = '0;
    if (e) begin
      model_trap(1'b0, int'(code), epc, tval, tvec, target);
      taken = 1'b1;
    end else if (ic >= 0 && (m_priv != 2'b11 || m_mie)) begin
      model_trap(1'b1, ic, epc, tval, tvec, target);
      taken = 1'b1;
    end else if (mr && m_priv == 2'b11) begin
      target = m_mepc;
      m_mie = m_mpie; m_mpie = 1'b1; m_priv = m_mpp; m_mpp = 2'b00;
      taken = 1'b1;
    end else if (we) begin
      model_csr_write(addr, wdata);
    end
    @(negedge clk);
    clear_inputs();
    if (taken) begin
      check({kind, "_valid"}, 64'(redirect_valid), 64'h1);
      check({kind, "_pc"}, redirect_pc, target);
      check({kind, "_busy"}, 64'(busy), 64'h1);
      check_csrs(kind);
      for (int i = 0; i < hold; i++) begin
        // Stray events while redirecting must be ignored; CSR writes still land.
        exc_valid = 1'($urandom_range(0, 1));
        exc_code = 6'($urandom_range(0, 19));
        mret_valid = 1'($urandom_range(0, 1));
        irq_pending = 16'($urandom);
        csr_we = 1'($urandom_range(0, 1));
        csr_addr = rand_addr();
        csr_wdata = {$urandom, $urandom};
        if (csr_we) model_csr_write(csr_addr, csr_wdata);
        @(negedge clk);
        clear_inputs();
        check({kind, "_hold_valid"}, 64'(redirect_valid), 64'h1);
        check({kind, "_hold_pc"}, redirect_pc, target);
        check_csrs({kind, "_hold"});
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      check({kind, "_done_valid"}, 64'(redirect_valid), 64'h0);
      check({kind, "_done_busy"}, 64'(busy), 64'h0);
    end else begin
      check({kind, "_noredir_valid"}, 64'(redirect_valid), 64'h0);
      check({kind, "_noredir_busy"}, 64'(busy), 64'h0);
    end
    check_csrs({kind, "_end"});
    $display("txn %0d: %s taken=%0b target=0x%0h mcause=0x%0h priv=%0d hold=%0d",
             txn_count++, kind, taken, target, m_mcause, m_priv, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_e, r_mr, r_we;
    logic [5:0]  r_code;
    logic [15:0] r_irq;
    logic [63:0] r_epc, r_tval, r_tvec, r_wdata;
    logic [11:0] r_addr;
    int          r_kind;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(redirect_valid), 64'h1);
    check("rst_pc", redirect_pc, BOOT_PC);
    check("rst_busy", 64'(busy), 64'h1);
    check_csrs("rst");
    rstn = 1'b1;
    boot_handshake(0);

    // Directed scenarios
    run_txn("exc2", 1'b1, 6'd2, 64'h8000_0004, 64'hDEAD, 1'b0, 16'h0, 64'h2000, 1'b0, 12'h0, 64'h0, 1);
    check("plan_exc_pc_mcause", mcause, 64'h2);
    check("plan_exc_mepc", mepc, 64'h8000_0004);
    run_txn("csr_mie", 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b1, 12'h300, 64'h8, 0);
    run_txn("irq7", 1'b0, 6'd0, 64'h8000_0010, 64'h55, 1'b0, 16'h0080, 64'h1001, 1'b0, 12'h0, 64'h0, 0);
    check("plan_irq_mcause", mcause, 64'h8000_0000_0000_0007);
    run_txn("csr_mie2", 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b1, 12'h300, 64'h1808, 0);
    run_txn("exc5_irq11", 1'b1, 6'd5, 64'h3000, 64'h77, 1'b0, 16'h0800, 64'h1001, 1'b0, 12'h0, 64'h0, 0);
    check("plan_prio_mcause", mcause, 64'h5);
    run_txn("mret_irqpend", 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 16'h0800, 64'h1001, 1'b0, 12'h0, 64'h0, 0);
    run_txn("irq11", 1'b0, 6'd0, 64'h3004, 64'h0, 1'b0, 16'h0800, 64'h1001, 1'b0, 12'h0, 64'h0, 0);
    check("plan_pend_mcause", mcause, 64'h8000_0000_0000_000B);
    run_txn("csr_mepc", 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b1, 12'h341, 64'h4000, 0);
    run_txn("csr_mstatus", 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b1, 12'h300, 64'h80, 0);
    run_txn("mret_u", 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 16'h0, 64'h0, 1'b0, 12'h0, 64'h0, 3);
    check("plan_mret_priv", 64'(priv), 64'h0);
    check("plan_mret_mie", 64'(mie), 64'h1);
    run_txn("mret_illegal", 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 16'h0, 64'h0, 1'b1, 12'h342, 64'h99, 0);
    run_txn("csr_wr_event_wins", 1'b1, 6'd13, 64'h5003, 64'h1, 1'b0, 16'h0, 64'h8000, 1'b1, 12'h341, 64'hFFF0, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      r_kind = $urandom_range(0, 4);
      r_e = (r_kind == 0) || (r_kind == 4 && $urandom_range(0, 2) == 0);
      r_irq = (r_kind == 1 || r_kind == 4) ? 16'($urandom) : 16'h0;
      r_mr = (r_kind == 2) || (r_kind == 4 && $urandom_range(0, 1) == 1);
      r_we = (r_kind == 3) || ($urandom_range(0, 3) == 0);
      r_code = 6'($urandom_range(0, 19));
      r_epc = {$urandom, $urandom};
      r_tval = {$urandom, $urandom};
      r_tvec = {$urandom, $urandom};
      r_addr = rand_addr();
      r_wdata = {$urandom, $urandom};
      run_txn("rand", r_e, r_code, r_epc, r_tval, r_mr, r_irq, r_tvec, r_we, r_addr, r_wdata,
              $urandom_range(0, 3));
    end

    // Reset pulsed while a redirect is outstanding
    check("pre_rst_busy", 64'(busy), 64'h0);
    exc_valid = 1'b1; exc_code = 6'd7; exc_epc = 64'h6000; exc_tval = 64'h1; mtvec = 64'h9000;
    @(negedge clk);
    clear_inputs();
    check("midrst_valid", 64'(redirect_valid), 64'h1);
    check("midrst_pc", redirect_pc, 64'h9000);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 64'(redirect_valid), 64'h1);
    check("async_rst_pc", redirect_pc, BOOT_PC);
    check("async_rst_busy", 64'(busy), 64'h1);
    check_csrs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    boot_handshake(2);
    run_txn("post_rst_exc", 1'b1, 6'd3, 64'h7001, 64'hBEEF, 1'b0, 16'h0, 64'h2003, 1'b0, 12'h0, 64'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer, directly downstream of the CSR/exception encoding stage.
- Consumes a synchronous exception, pending-interrupt vector, or MRET from commit.
- Updates trap CSRs: mepc, mcause, mtval, the mstatus MIE/MPIE/MPP fields and the current privilege level.
- Issues a valid/ready PC redirect to fetch: the boot address after reset, the mtvec target on a trap, or mepc on MRET.

Parameters:
- MXLEN, 64, data/address width.
- BOOT_ADDRESS, 62'h100, word-aligned boot base; boot PC = {BOOT_ADDRESS, 2'b00} = 0x400.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- exc_valid_i  in  1  synchronous exception at commit.
- exc_code_i  in  6  synchronous exception code (0..19).
- exc_epc_i  in  MXLEN  PC of the faulting instruction.
- exc_tval_i  in  MXLEN  trap value.
- mret_valid_i  in  1  MRET committed.
- irq_pending_i  in  16  mip & mie, bit index = interrupt code.
- mtvec_i  in  MXLEN  {base[61:0], mode[1:0]}.
- csr_we_i  in  1  CSR write strobe.
- csr_addr_i  in  12  CSR address (0x300, 0x341, 0x342, 0x343 decoded; all others ignored).
- csr_wdata_i  in  MXLEN  CSR write data.
- busy_o  out  1  state != IDLE; producers must not issue events while high.
- redirect_valid_o  out  1  redirect request.
- redirect_ready_i  in  1  fetch accepts the redirect.
- redirect_pc_o  out  MXLEN  redirect target.
- mepc_o, mcause_o, mtval_o  out  MXLEN  CSR contents.
- mstatus_mie_o, mstatus_mpie_o  out  1  mstatus fields.
- mstatus_mpp_o  out  2  mstatus.MPP.
- priv_o  out  2  current privilege (00 U, 01 S, 11 M).

Behaviour:
- Reset values:
  - State BOOT; redirect_valid_o=1; redirect_pc_o=0x400; busy_o=1.
  - priv_o=11; mstatus_mpp_o=11; MIE=0; MPIE=0.
  - mepc_o, mcause_o, mtval_o = 0.
- FSM states BOOT, IDLE, REDIRECT:
  - BOOT -> IDLE on redirect_ready_i.
  - IDLE -> REDIRECT on an accepted event.
  - REDIRECT -> IDLE on redirect_ready_i.
- redirect_valid_o and redirect_pc_o are registered and held stable until the handshake completes.
- Event priority in IDLE, one event per cycle:
  1. exc_valid_i.
  2. Interrupt: irq_pending_i!=0 and (priv_o!=11 or MIE=1).
  3. mret_valid_i.
  - Lower-priority events in the same cycle are dropped.
- Interrupt selection order: 11, 3, 7, 9, 1, 5, 13. Bits outside this set are ignored.
- Trap entry, registered at the clock edge, redirect_valid_o high on the next cycle:
  - mepc = exc_epc_i with bit0 forced 0. For an interrupt, mepc = exc_epc_i (the next PC supplied by commit).
  - mcause = {interrupt, zero-extended code}.
  - mtval = exc_tval_i for an exception, 0 for an interrupt.
  - MPIE = MIE; MIE = 0; MPP = priv_o; priv_o = 11.
- Trap target:
  - {base, 2'b00} for exceptions and in DIRECT mode.
  - {base, 2'b00} + 4*code for interrupts in VECTORED mode.
  - mtvec mode 2 or 3 is treated as DIRECT.
  - Addition wraps modulo 2^MXLEN.
- MRET:
  - MIE = MPIE; MPIE = 1; priv_o = MPP; MPP = 00.
  - Redirect to mepc_o.
  - If priv_o is not 11, MRET is ignored (illegal; upstream has already flagged it).
- CSR writes (any state except during a trap entry or MRET update cycle, where the event wins):
  - 0x300 updates MIE (bit3), MPIE (bit7), MPP (bits12:11). An MPP write of 10 is WARL: keep the old value.
  - 0x341 mepc: bit0 forced 0.
  - 0x342 mcause: full write.
  - 0x343 mtval: full write.
- Events in BOOT or REDIRECT are ignored and no state is updated.
- Reset asserted mid-REDIRECT: all state returns to reset values and the boot redirect is reissued.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: VECTORED mode behaves as above.
- Undefined: mtvec mode is ignored and every trap targets {base, 2'b00}.

Test Plan:
- Reset, release, hold redirect_ready_i=1 -> 0x400 redirected for one cycle; then busy_o=0, priv_o=11, mcause_o=0.
- Exception: exc_code_i=2, epc=0x8000_0004, tval=0xDEAD, mtvec=0x2000 -> redirect 0x2000; mcause=2; mepc=0x8000_0004; mtval=0xDEAD; MIE=0.
- MIE=1 (CSR write 0x300 = 0x8), irq_pending_i bit7, mtvec=0x1001 -> mcause=0x8000_0000_0000_0007; redirect 0x101C (0x1000 without TRAP_VECTORED_EN).
- Same-cycle exc_valid_i (code 5) and irq bit11 -> exception taken with mcause=5; interrupt pends and is taken after returning to IDLE.
- MRET with MPP=00, MPIE=1, mepc=0x4000 -> redirect 0x4000; priv_o=00; MIE=1; MPP=00. Redirect held stable for 3 cycles with redirect_ready_i=0.
- rstn_i pulsed low during REDIRECT -> outputs immediately at reset values; boot redirect to 0x400 follows.
